// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DFLT     = 11;
  localparam int unsigned DATA_W_DFLT     = 32;
  localparam int unsigned STARVE_MAX_DFLT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and RAM signals of the memory port arbiter; slave = arbiter side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
           ram_addr, ram_wdata, ram_w_en
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
           ram_addr, ram_wdata, ram_w_en
  );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of consecutive denied fetch cycles; raises force_win at the limit.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_q;

  always_ff @(posedge clk) begin
    if (rst || !req || gnt) begin
      starve_q <= '0;
    end else if (starve_q != LIMIT) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  assign force_win = req && (starve_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single synchronous-read RAM with starvation guard.
// Optional perf counters under MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DFLT,
  parameter int unsigned DATA_W     = DATA_W_DFLT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]        perf_if_wait,
  output logic [31:0]        perf_dm_ops
`endif
);

  owner_t            owner_q, owner_d;
  logic              force_win;
  logic              if_gnt, dm_gnt, ram_w_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] rdata;

  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.if_req),
    .gnt       (if_gnt),
    .force_win (force_win)
  );

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    ram_addr = '0;
    ram_w_en = 1'b0;
    owner_d  = OWN_NONE;
    if (!rst) begin
      if (force_win)       if_gnt = 1'b1;
      else if (bus.dm_req) dm_gnt = 1'b1;
      else if (bus.if_req) if_gnt = 1'b1;
    end
    if (dm_gnt) begin
      ram_addr = bus.dm_addr;
      ram_w_en = bus.dm_we;
      owner_d  = OWN_DM;
    end else if (if_gnt) begin
      ram_addr = bus.if_addr;
      owner_d  = OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  assign rdata         = bus.ram_rdata;
  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_w_en  = ram_w_en;
  assign bus.ram_wdata = bus.dm_wdata;
  assign bus.if_rdata  = rdata;
  assign bus.dm_rdata  = rdata;
  // Gated by rst so an access caught by reset never reports completion.
  assign bus.if_valid  = (owner_q == OWN_IF) && !rst;
  assign bus.dm_valid  = (owner_q == OWN_DM) && !rst;

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_dm_ops  <= '0;
    end else begin
      if (bus.if_req && !if_gnt && perf_if_wait != '1) perf_if_wait <= perf_if_wait + 32'd1;
      if (dm_gnt && perf_dm_ops != '1)                 perf_dm_ops  <= perf_dm_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a write-first synchronous RAM model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_dm_ops;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_ops  (perf_dm_ops)
`endif
  );

  // RAM: word i preloaded with 0xA000_0000 + i, write-first read.
  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] rd_q;
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      init_done <= 1'b1;
    end else if (bus.ram_w_en) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      rd_q              <= bus.ram_wdata;
    end else begin
      rd_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = rd_q;

  typedef struct {
    logic        is_dm;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_valid === 1'b1 || bus.dm_valid === 1'b1) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: if_valid=%b dm_valid=%b expected no completion at %0t",
                 bus.if_valid, bus.dm_valid, $time);
      end else begin
        mon_e = q.pop_front();
        chk("if_valid", 32'(bus.if_valid), 32'(!mon_e.is_dm));
        chk("dm_valid", 32'(bus.dm_valid), 32'(mon_e.is_dm));
        if (mon_e.chk) begin
          if (mon_e.is_dm) chk("dm_rdata", bus.dm_rdata, mon_e.data);
          else             chk("if_rdata", bus.if_rdata, mon_e.data);
        end
      end
    end
  end

  // One cycle of stimulus; eig/edg are the expected grants, ed the expected read word.
  task automatic step(input logic r, input logic ir, input logic [10:0] ia,
                      input logic dr, input logic dw, input logic [10:0] da,
                      input logic [31:0] dwd, input logic eig, input logic edg,
                      input logic [31:0] ed, input logic ret);
    logic [10:0] ea;
    rst          = r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
    ea = edg ? da : (eig ? ia : 11'd0);
    @(negedge clk);
    chk("if_gnt",   32'(bus.if_gnt),   32'(eig));
    chk("dm_gnt",   32'(bus.dm_gnt),   32'(edg));
    chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
    chk("ram_w_en", 32'(bus.ram_w_en), 32'(edg & dw));
    if (edg && dw) chk("ram_wdata", bus.ram_wdata, dwd);
    if (r) begin
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
    end
    if (ret && eig) q.push_back('{is_dm: 1'b0, chk: 1'b1, data: ed});
    if (ret && edg) q.push_back('{is_dm: 1'b1, chk: !dw, data: ed});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    @(posedge clk);
    #1;

    // Reset with both requesters active (including a store): nothing granted or written.
    step(1'b1, 1'b1, 11'h005, 1'b1, 1'b1, 11'h007, 32'h1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 11'h005, 1'b1, 1'b1, 11'h007, 32'h1, 1'b0, 1'b0, 32'd0, 1'b0);

    // Continuous contention: dm,dm,dm,dm,if repeating.
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        step(1'b0, 1'b1, 11'h030, 1'b1, 1'b0, 11'h020, 32'd0, 1'b1, 1'b0, 32'hA000_0030, 1'b1);
      else
        step(1'b0, 1'b1, 11'h030, 1'b1, 1'b0, 11'h020, 32'd0, 1'b0, 1'b1, 32'hA000_0020, 1'b1);
    end
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_if_wait", perf_if_wait, 32'd8);
    chk("perf_dm_ops",  perf_dm_ops,  32'd8);
`endif
    idle();

    // Fetch-only stream.
    for (int a = 0; a < 4; a++)
      step(1'b0, 1'b1, 11'(a), 1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 32'hA000_0000 + 32'(a), 1'b1);
    idle();

    // Store then load the same word.
    step(1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'h010, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0, 1'b1);
    step(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'h010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    idle();

    // Requests rise together once: data first, fetch next cycle.
    step(1'b0, 1'b1, 11'h040, 1'b1, 1'b0, 11'h041, 32'd0, 1'b0, 1'b1, 32'hA000_0041, 1'b1);
    step(1'b0, 1'b1, 11'h040, 1'b0, 1'b0, 11'h000, 32'd0, 1'b1, 1'b0, 32'hA000_0040, 1'b1);
    idle();

    // Reset right after a fetch grant: that fetch never completes.
    step(1'b0, 1'b1, 11'h005, 1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 11'h005, 1'b1, 1'b1, 11'h007, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 11'h005, 1'b1, 1'b1, 11'h007, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 11'h006, 1'b0, 1'b0, 11'd0, 32'd0, 1'b1, 1'b0, 32'hA000_0006, 1'b1);
    // Word 7 must be untouched by the store attempted during reset.
    step(1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'h007, 32'd0, 1'b0, 1'b1, 32'hA000_0007, 1'b1);
    idle();
    idle();

    chk("pending_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
